// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready).
interface uart_rx_frontend_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frontend_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_do;
    logic             pop_do;

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(DEPTH));
    assign pop_do   = pop && !empty;
    assign push_do  = push && (!full || pop_do);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_do, pop_do})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: rx synchroniser, mid-bit sampling FSM and byte FIFO
// presented as a valid/ready stream with error pulses.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    uart_rx_frontend_if.master           stream,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);

    logic                   rx_m;
    logic                   rx_s;
    uart_rx_state_e         state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic stop_hit;
    logic push;

    // Two-flop synchroniser; idles high so reset looks like an idle line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // The push happens on the stop-sample edge itself so rx_valid rises one cycle later
    assign stop_hit = (state == ST_STOP) && (cnt == BIT_END);
    assign push     = stop_hit && rx_s;
    assign fifo_pop = stream.rx_valid && stream.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            overrun <= fifo_full && !fifo_pop;
                            state   <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low (break) line must not start a new frame
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (stream.rx_data),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign stream.rx_valid = !fifo_empty;
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Receive-side UART front end between the board `rx` pin and the SoC's byte consumer. It synchronises the asynchronous `rx` line and decodes 8N1 frames with a per-bit counter, sampling each bit at mid-bit. Decoded bytes are buffered in a small FIFO and delivered over a valid/ready stream. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: frequency of `clk`.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 16: byte buffer depth; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock, 100 MHz domain.
- `rst`  in  1: synchronous reset, active-high.
- `rx`  in  1: asynchronous serial input; idles high.
- `rx_data`  out  8: head-of-FIFO byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1: FIFO not empty.
- `rx_ready`  in  1: consumer accepts the head byte.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current byte count.

## Operation
- Constants: `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` (integer floor; 868 at the defaults) and `HALF = CLKS_PER_BIT / 2`.
- Synchroniser: two flops on `rx`, both reset to 1. All decoding uses the second flop, `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rx_s` is 0, go to START and clear the bit counter.
- START: when the counter reaches HALF-1, check `rx_s`:
  - 0: go to DATA and clear the counter.
  - 1: glitch; go back to IDLE.
- DATA: each time the counter reaches CLKS_PER_BIT-1, shift `rx_s` into the shift register LSB-first and clear the counter. After 8 bits, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample `rx_s`:
  - 1: push the shift register into the FIFO and go to IDLE. If no space is available, drop the byte and pulse `overrun`.
  - 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This handles break conditions: a held-low line produces exactly one `frame_err`.
- FIFO: first-word-fall-through. `rx_data` shows the head entry and `rx_valid` equals not-empty. A pop occurs when `rx_valid && rx_ready`.
- Space rule: a push is accepted when `fifo_level < FIFO_DEPTH`, or when a pop occurs in the same cycle.
- Simultaneous push and pop: `fifo_level` stays the same, and the head advances.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` saturates neither way; the space rule prevents overflow, and `rx_valid` gating prevents underflow.

## Timing
- Reset values:
  - `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `fifo_level` = 0.
  - FSM in IDLE, synchroniser = 1, counter = 0, FIFO empty.
- Reset mid-frame: the partial frame is discarded and FIFO contents are lost. The first frame after reset decodes normally.
- Pin-to-decode latency: 2 cycles through the synchroniser, then 1 cycle for IDLE to detect the low level.
- Stop sample timing: the stop bit is sampled HALF + 9·CLKS_PER_BIT cycles (±1) after the FSM leaves IDLE.
- Output timing after the stop sample:
  - `rx_valid` rises on the cycle after the stop sample.
  - `frame_err` and `overrun` pulse on the cycle after the stop sample.
- Pop timing: after a pop, `rx_data` shows the next entry on the following cycle.
- Frame spacing: back-to-back frames with no idle gap are accepted, because the FSM re-enters IDLE before the next start edge.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_e` enum covering the five FSM states.
  - `clks_per_bit(freq, baud)` function.
  - `UART_DATA_W = 8`.
- Sub-module `sync_fifo`:
  - Parameterised width and depth.
  - Exposes push/full and pop/empty, plus a level output.
  - Instantiated once with width 8.
- The synchroniser and FSM live in `uart_rx_frontend` itself.

## Test plan
All scenarios use CLK_FREQ_HZ = 1_600_000, BAUD = 100_000 (CLKS_PER_BIT = 16), FIFO_DEPTH = 16.

- **Single byte:** `rx_ready` = 1, send frame 0x55 → one `rx_valid` cycle with `rx_data` = 0x55; `frame_err` and `overrun` never assert.
- **Glitch rejection:** drive `rx` low for 5 cycles, then high → FSM returns to IDLE; no `rx_valid`, no `frame_err`.
- **Framing error and break:** send 0xA3 with the stop bit 0, hold `rx` low 40 more cycles, then send 0x3C → exactly one `frame_err` pulse, 0xA3 never appears, 0x3C is received.
- **Overrun and drain:** `rx_ready` = 0, send 0x00..0x10 (17 bytes) → `fifo_level` = 16 and one `overrun` pulse on the 17th byte; then `rx_ready` = 1 drains 0x00..0x0F in order, ending at level 0.
- **Full with same-cycle pop:** FIFO full; pulse `rx_ready` exactly on the stop-sample push cycle → byte accepted, no `overrun`, `fifo_level` stays 16.
- **Reset mid-frame:** assert `rst` for 1 cycle in the middle of bit 3 of a frame → all outputs return to reset values; the next 0xC6 frame is received correctly.
